// File: rtl/if_fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: owns the fetch PC, selects the
// next PC (sequential, branch/jump, ERET, exception entry), holds a branch
// redirect that arrives while stalled, and flags AdEL on bad fetch addresses.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] HANDLER  = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        npc_sel,
  input  logic [31:0] npc_target,
  input  logic        d_is_jump,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        bd_out,
  output logic [4:0]  exc_out,
  output logic        redirect_pending
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        addr_err;

  // Fetch address legality: word aligned and inside the text segment.
  always_comb begin
    addr_err = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
  end

  assign i_inst_addr      = pc;
  assign pc_out           = pc;
  assign exc_out          = addr_err ? EXC_ADEL : 5'd0;
  assign instr_out        = addr_err ? 32'h0 : i_inst_rdata;
  assign bd_out           = d_is_jump;
  assign redirect_pending = pend_valid;

  // Next-PC selection; a flush beats everything, and a stall parks any
  // branch redirect so it is not lost while F is frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= PC_RESET;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
    end else if (req) begin
      pc         <= HANDLER;
      pend_valid <= 1'b0;
    end else if (!en) begin
      if (npc_sel) begin
        pend_valid  <= 1'b1;
        pend_target <= npc_target;
      end
    end else if (eret) begin
      pc         <= epc;
      pend_valid <= 1'b0;
    end else if (npc_sel) begin
      pc         <= npc_target;
      pend_valid <= 1'b0;
    end else if (pend_valid) begin
      pc         <= pend_target;
      pend_valid <= 1'b0;
    end else begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = 32'h0;
  logic        npc_sel = 1'b0;
  logic [31:0] npc_target = 32'h0;
  logic        d_is_jump = 1'b0;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        bd_out;
  logic [4:0]  exc_out;
  logic        redirect_pending;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_held_tgt;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .eret(eret), .epc(epc),
    .npc_sel(npc_sel), .npc_target(npc_target), .d_is_jump(d_is_jump),
    .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .bd_out(bd_out),
    .exc_out(exc_out), .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  assign i_inst_rdata = mem(i_inst_addr);

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFC);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transition per clock following the priority rules
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 32'h3000; m_held = 0; m_held_tgt = 32'h0;
    end else if (req) begin
      m_pc = 32'h4180; m_held = 0;
    end else if (!en) begin
      if (npc_sel) begin m_held = 1; m_held_tgt = npc_target; end
    end else begin
      if (eret)         m_pc = epc;
      else if (npc_sel) m_pc = npc_target;
      else if (m_held)  m_pc = m_held_tgt;
      else              m_pc = m_pc + 32'd4;
      m_held = 0;
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en && reset) begin
      check("pc_out", pc_out, m_pc);
      check("i_inst_addr", i_inst_addr, m_pc);
      check("exc_out", {27'h0, exc_out}, legal(m_pc) ? 32'd0 : 32'd4);
      check("instr_out", instr_out, legal(m_pc) ? mem(m_pc) : 32'h0);
      check("bd_out", {31'h0, bd_out}, {31'h0, d_is_jump});
      check("redirect_pending", {31'h0, redirect_pending}, {31'h0, m_held});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    en = 1'b1; req = 1'b0; eret = 1'b0; npc_sel = 1'b0; d_is_jump = 1'b0;
  endtask

  initial begin
    // Reset held across two edges
    repeat (2) @(posedge clk);
    #2;
    check("reset_pc", pc_out, 32'h3000);
    check("reset_exc", {27'h0, exc_out}, 32'h0);
    check("reset_pend", {31'h0, redirect_pending}, 32'h0);
    reset = 1'b1;
    chk_en = 1'b1;
    clear();
    repeat (4) tick();
    check("seq_3010", pc_out, 32'h3010);

    // Asynchronous reset mid-cycle
    #1; reset = 1'b0; #1;
    check("async_reset_pc", pc_out, 32'h3000);
    reset = 1'b1;
    tick(); check("after_reset_1", pc_out, 32'h3004);
    tick(); check("after_reset_2", pc_out, 32'h3008);
    tick(); check("after_reset_3", pc_out, 32'h300C);

    // Branch with delay slot flag
    npc_sel = 1'b1; npc_target = 32'h3008; tick();
    check("branch_setup", pc_out, 32'h3008);
    npc_target = 32'h3040; d_is_jump = 1'b1; #1;
    check("bd_out_set", {31'h0, bd_out}, 32'h1);
    tick(); clear();
    check("branch_taken", pc_out, 32'h3040);

    // Redirect held across a stall
    en = 1'b0; npc_sel = 1'b1; npc_target = 32'h3100; tick();
    npc_sel = 1'b0;
    check("stall_hold_pc", pc_out, 32'h3040);
    check("stall_pend", {31'h0, redirect_pending}, 32'h1);
    tick(); tick();
    check("stall_hold_pc2", pc_out, 32'h3040);
    check("stall_pend2", {31'h0, redirect_pending}, 32'h1);
    en = 1'b1; tick();
    check("held_redirect", pc_out, 32'h3100);
    check("held_cleared", {31'h0, redirect_pending}, 32'h0);

    // Exception beats eret and stalled branch
    en = 1'b0; req = 1'b1; eret = 1'b1; epc = 32'h3024;
    npc_sel = 1'b1; npc_target = 32'h3200; tick(); clear();
    check("exc_handler", pc_out, 32'h4180);
    check("exc_no_pend", {31'h0, redirect_pending}, 32'h0);

    // ERET
    eret = 1'b1; epc = 32'h3024; tick(); clear();
    check("eret_pc", pc_out, 32'h3024);

    // eret ignored while stalled
    en = 1'b0; eret = 1'b1; epc = 32'h3500; tick(); clear();
    check("eret_stalled", pc_out, 32'h3024);

    // Address errors
    eret = 1'b1; epc = 32'h3002; tick(); clear();
    check("misalign_exc", {27'h0, exc_out}, 32'd4);
    check("misalign_instr", instr_out, 32'h0);
    npc_sel = 1'b1; npc_target = 32'h7000; tick(); clear();
    check("above_hi_exc", {27'h0, exc_out}, 32'd4);
    npc_sel = 1'b1; npc_target = 32'h6FFC; tick(); clear();
    check("top_word_exc", {27'h0, exc_out}, 32'd0);
    check("top_word_instr", instr_out, mem(32'h6FFC));
    tick();
    check("seq_7000_pc", pc_out, 32'h7000);
    check("seq_7000_exc", {27'h0, exc_out}, 32'd4);
    npc_sel = 1'b1; npc_target = 32'hFFFF_FFFC; tick(); clear();
    tick();
    check("wrap_pc", pc_out, 32'h0);
    check("wrap_exc", {27'h0, exc_out}, 32'd4);

    // Later stalled branch overwrites held target
    en = 1'b0; npc_sel = 1'b1; npc_target = 32'h3300; tick();
    npc_target = 32'h3304; tick(); clear(); tick();
    check("overwrite_pend", pc_out, 32'h3304);

    // Live branch beats held redirect
    en = 1'b0; npc_sel = 1'b1; npc_target = 32'h3400; tick();
    en = 1'b1; npc_target = 32'h3500; tick(); clear();
    check("live_beats_held", pc_out, 32'h3500);
    check("live_clears_pend", {31'h0, redirect_pending}, 32'h0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      req       = ($urandom_range(0, 15) == 0);
      eret      = ($urandom_range(0, 9) == 0);
      npc_sel   = ($urandom_range(0, 3) == 0);
      d_is_jump = $urandom_range(0, 1);
      npc_target = ($urandom_range(0, 7) == 0) ? $urandom
                   : 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
      epc        = ($urandom_range(0, 7) == 0) ? $urandom
                   : 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
      if ($urandom_range(0, 199) == 0) begin
        #1; reset = 1'b0; #1; reset = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
